// File: rtl/fp_up_converter.sv
// binary32 -> binary64 widening converter (FCVT.D.S), two-stage valid/ready pipeline with flush.
// Optional NaN-box check on in[63:32] is enabled by defining FP_UPCVT_NANBOX_CHECK_EN.
module fp_up_converter #(
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        io_flush,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [63:0] io_in,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [63:0] io_result,
    output logic [4:0]  io_fflags
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN,
        CLS_UNBOXED
    } cls_t;

    localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    // Only the two-stage arrangement exists; the parameter is carried for interface compatibility.
    logic w_unused_latency;
    assign w_unused_latency = (LATENCY != 2);

    function automatic logic [4:0] f_lzc23(input logic [22:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        if (!found) n = 5'd0;
        return n;
    endfunction

    logic        w_in_sign;
    logic [7:0]  w_in_exp;
    logic [22:0] w_in_man;
    logic        w_in_unboxed;
    cls_t        w_in_cls;
    logic [4:0]  w_in_lz;

    assign w_in_sign = io_in[31];
    assign w_in_exp  = io_in[30:23];
    assign w_in_man  = io_in[22:0];
    assign w_in_lz   = f_lzc23(w_in_man);

`ifdef FP_UPCVT_NANBOX_CHECK_EN
    assign w_in_unboxed = (io_in[63:32] != 32'hFFFF_FFFF);
`else
    logic w_unused_box;
    assign w_unused_box = ^io_in[63:32];
    assign w_in_unboxed = 1'b0;
`endif

    always_comb begin
        w_in_cls = CLS_NORM;
        if (w_in_unboxed) begin
            w_in_cls = CLS_UNBOXED;
        end else if (w_in_exp == 8'hFF) begin
            if (w_in_man == 23'd0)  w_in_cls = CLS_INF;
            else if (w_in_man[22])  w_in_cls = CLS_QNAN;
            else                    w_in_cls = CLS_SNAN;
        end else if (w_in_exp == 8'h00) begin
            if (w_in_man == 23'd0)  w_in_cls = CLS_ZERO;
            else                    w_in_cls = CLS_SUB;
        end
    end

    // Handshake: S2 frees up when empty or drained; S1 can refill whenever it moves on.
    logic w_s2_adv;
    logic w_in_fire;

    logic        r_s1_valid;
    logic        r_s1_sign;
    cls_t        r_s1_cls;
    logic [7:0]  r_s1_exp;
    logic [22:0] r_s1_man;
    logic [4:0]  r_s1_lz;

    logic        r_s2_valid;
    logic [63:0] r_s2_result;
    logic [4:0]  r_s2_fflags;

    assign w_s2_adv    = !r_s2_valid || io_out_ready;
    assign io_in_ready = !r_s1_valid || w_s2_adv;
    assign w_in_fire   = io_in_valid && io_in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
        end else if (io_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_sign <= 1'b0;
            r_s1_cls  <= CLS_ZERO;
            r_s1_exp  <= 8'd0;
            r_s1_man  <= 23'd0;
            r_s1_lz   <= 5'd0;
        end else if (w_in_fire) begin
            r_s1_sign <= w_in_sign;
            r_s1_cls  <= w_in_cls;
            r_s1_exp  <= w_in_exp;
            r_s1_man  <= w_in_man;
            r_s1_lz   <= w_in_lz;
        end
    end

    // Subnormals: shift out the leading one so it becomes the implicit bit of the wider format.
    logic [10:0] w_norm_exp;
    logic [10:0] w_sub_exp;
    logic [23:0] w_sub_shift;
    logic [63:0] w_pack_result;
    logic [4:0]  w_pack_fflags;

    assign w_norm_exp  = {3'b000, r_s1_exp} + 11'd896;
    assign w_sub_exp   = 11'd896 - {6'b000000, r_s1_lz};
    assign w_sub_shift = {1'b0, r_s1_man} << (r_s1_lz + 5'd1);

    always_comb begin
        w_pack_result = CANON_NAN;
        w_pack_fflags = 5'b00000;
        case (r_s1_cls)
            CLS_ZERO: w_pack_result = {r_s1_sign, 63'd0};
            CLS_SUB:  w_pack_result = {r_s1_sign, w_sub_exp, w_sub_shift[22:0], 29'd0};
            CLS_NORM: w_pack_result = {r_s1_sign, w_norm_exp, r_s1_man, 29'd0};
            CLS_INF:  w_pack_result = {r_s1_sign, 11'h7FF, 52'd0};
            CLS_SNAN: begin
                w_pack_result = CANON_NAN;
                w_pack_fflags = 5'b10000;
            end
            default:  w_pack_result = CANON_NAN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
        end else if (io_flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_result <= 64'd0;
            r_s2_fflags <= 5'd0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_s2_result <= w_pack_result;
            r_s2_fflags <= w_pack_fflags;
        end
    end

    assign io_out_valid = r_s2_valid;
    assign io_result    = r_s2_result;
    assign io_fflags    = r_s2_fflags;

endmodule

// File: tb/tb_fp_up_converter.sv
// Self-checking bench for fp_up_converter: directed vectors, backpressure, flush, reset and a random stream
// against a value-level reference model (honours FP_UPCVT_NANBOX_CHECK_EN).
module tb_fp_up_converter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        io_flush;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [63:0] io_in;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_result;
    logic [4:0]  io_fflags;

    localparam logic [63:0] CNAN = 64'h7FF8_0000_0000_0000;

    int          n_vec = 0;
    int          n_err = 0;
    logic [68:0] sb_q[$];
    logic        last_acc;

    fp_up_converter #(.LATENCY(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_flush     (io_flush),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in        (io_in),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_result    (io_result),
        .io_fflags    (io_fflags)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value model: finite input = sig * 2^ex, normalised until the leading one sits at bit 23.
    function automatic void ref_conv(input logic [63:0] x, output logic [63:0] r, output logic [4:0] f);
        logic        s;
        int          e;
        int unsigned m;
        int unsigned sig;
        int          ex;
        int          bexp;
        int unsigned frac;
        s = x[31];
        e = int'(x[30:23]);
        m = 32'(x[22:0]);
        f = 5'd0;
        r = CNAN;
`ifdef FP_UPCVT_NANBOX_CHECK_EN
        if (x[63:32] != 32'hFFFF_FFFF) return;
`endif
        if (e == 255) begin
            if (m == 0) r = {s, 11'h7FF, 52'd0};
            else if (m < 32'h0040_0000) f = 5'b10000;
            return;
        end
        if (e == 0 && m == 0) begin
            r = {s, 63'd0};
            return;
        end
        sig = (e == 0) ? m : (m + 32'h0080_0000);
        ex  = (e == 0) ? -149 : (e - 150);
        while (sig < 32'h0080_0000) begin
            sig = sig * 2;
            ex  = ex - 1;
        end
        bexp = ex + 23 + 1023;
        frac = sig - 32'h0080_0000;
        r = {s, bexp[10:0], frac[22:0], 29'd0};
    endfunction

    function automatic logic [63:0] rand_op();
        logic [31:0] w;
        logic [31:0] hi;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0: w[30:23] = 8'h00;
            1: w[30:23] = 8'hFF;
            2: begin w[30:23] = 8'h00; w[22:0] = 23'd0; end
            3: begin w[30:23] = 8'hFF; w[22] = 1'b0; end
            default: ;
        endcase
        hi = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
        return {hi, w};
    endfunction

    // One clock: observe handshakes at the falling edge, update the scoreboard, return 1 after the rising edge.
    task automatic tick();
        logic        acc;
        logic        outx;
        logic [68:0] e;
        logic [63:0] r;
        logic [4:0]  f;
        @(negedge clock);
        acc  = io_in_valid && io_in_ready;
        outx = io_out_valid && io_out_ready;
        if (outx) begin
            chk("sb_expect_out", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_result", io_result, e[63:0]);
                chk("sb_fflags", 64'(io_fflags), 64'(e[68:64]));
            end
        end
        if (io_flush) begin
            sb_q.delete();
        end else if (acc) begin
            ref_conv(io_in, r, f);
            sb_q.push_back({f, r});
        end
        last_acc = acc && !io_flush;
        @(posedge clock);
        #1;
    endtask

    task automatic directed(input string tag, input logic [63:0] x, input logic [63:0] er, input logic [4:0] ef);
        io_out_ready = 1'b1;
        io_in        = x;
        io_in_valid  = 1'b1;
        tick();
        chk({tag, "_accept"}, 64'(last_acc), 64'd1);
        io_in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(io_out_valid), 64'd0);
        tick();
        chk({tag, "_lat2_valid"}, 64'(io_out_valid), 64'd1);
        chk({tag, "_result"}, io_result, er);
        chk({tag, "_fflags"}, 64'(io_fflags), 64'(ef));
        tick();
    endtask

    initial begin
        logic [63:0] ops [4];
        logic [63:0] exp_r;
        logic [4:0]  exp_f;
        int          accepts;

        reset_n      = 1'b1;
        io_flush     = 1'b0;
        io_in_valid  = 1'b0;
        io_in        = 64'd0;
        io_out_ready = 1'b0;
        last_acc     = 1'b0;
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(io_out_valid), 64'd0);
        chk("rst_result", io_result, 64'd0);
        chk("rst_fflags", 64'(io_fflags), 64'd0);
        chk("rst_in_ready", 64'(io_in_ready), 64'd1);
        reset_n = 1'b1;

        directed("one",     64'hFFFFFFFF_3F800000, 64'h3FF0_0000_0000_0000, 5'h00);
        directed("sub_min", 64'hFFFFFFFF_00000001, 64'h36A0_0000_0000_0000, 5'h00);
        directed("sub_neg", 64'hFFFFFFFF_80400000, 64'hB800_0000_0000_0000, 5'h00);
        directed("max_nrm", 64'hFFFFFFFF_7F7FFFFF, 64'h47EF_FFFF_E000_0000, 5'h00);
        directed("snan",    64'hFFFFFFFF_7F800001, CNAN,                    5'h10);
        directed("qnan",    64'hFFFFFFFF_FFC00123, CNAN,                    5'h00);
        directed("ninf",    64'hFFFFFFFF_FF800000, 64'hFFF0_0000_0000_0000, 5'h00);
        directed("nzero",   64'hFFFFFFFF_80000000, 64'h8000_0000_0000_0000, 5'h00);
`ifdef FP_UPCVT_NANBOX_CHECK_EN
        directed("unboxed", 64'h00000000_3F800000, CNAN,                    5'h00);
`else
        directed("unboxed", 64'h00000000_3F800000, 64'h3FF0_0000_0000_0000, 5'h00);
`endif

        // Backpressure: consumer stalls for 5 cycles while four operands are offered back to back.
        for (int i = 0; i < 4; i++) ops[i] = rand_op();
        ref_conv(ops[0], exp_r, exp_f);
        accepts      = 0;
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            io_in = ops[accepts];
            tick();
            if (last_acc) accepts++;
            if (c >= 1) begin
                chk("bp_hold_valid", 64'(io_out_valid), 64'd1);
                chk("bp_hold_result", io_result, exp_r);
                chk("bp_hold_fflags", 64'(io_fflags), 64'(exp_f));
                chk("bp_in_ready_low", 64'(io_in_ready), 64'd0);
            end
        end
        chk("bp_accepts_stalled", 64'(accepts), 64'd2);
        io_out_ready = 1'b1;
        for (int c = 0; c < 20 && !(accepts == 4 && sb_q.size() == 0); c++) begin
            if (accepts < 4) begin
                io_in_valid = 1'b1;
                io_in       = ops[accepts];
            end else begin
                io_in_valid = 1'b0;
            end
            tick();
            if (last_acc) accepts++;
        end
        io_in_valid = 1'b0;
        chk("bp_accepts_total", 64'(accepts), 64'd4);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);

        // Flush with two entries in flight plus a third operand offered in the flush cycle.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_in        = rand_op();
        tick();
        io_in = rand_op();
        tick();
        chk("fl_pre_valid", 64'(io_out_valid), 64'd1);
        io_flush = 1'b1;
        io_in    = rand_op();
        tick();
        io_flush    = 1'b0;
        io_in_valid = 1'b0;
        chk("fl_out_valid", 64'(io_out_valid), 64'd0);
        io_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fl_no_stale", 64'(io_out_valid), 64'd0);
        end

        // Random stream with random stalls and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            io_in_valid  = ($urandom_range(0, 3) != 0);
            io_in        = rand_op();
            io_out_ready = ($urandom_range(0, 3) != 0);
            io_flush     = ($urandom_range(0, 29) == 0);
            tick();
        end
        io_flush     = 1'b0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick();
        chk("rand_drained", 64'(sb_q.size()), 64'd0);
        tick();
        chk("rand_idle_valid", 64'(io_out_valid), 64'd0);

        // Asynchronous reset in the middle of a stalled stream.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_in        = 64'hFFFFFFFF_3F800000;
        tick();
        io_in = 64'hFFFFFFFF_C0000000;
        tick();
        chk("mr_pre_valid", 64'(io_out_valid), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(io_out_valid), 64'd0);
        chk("mr_result", io_result, 64'd0);
        chk("mr_fflags", 64'(io_fflags), 64'd0);
        chk("mr_in_ready", 64'(io_in_ready), 64'd1);
        sb_q.delete();
        io_in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("mr_post_in_ready", 64'(io_in_ready), 64'd1);
        chk("mr_post_valid", 64'(io_out_valid), 64'd0);
        directed("post_rst", 64'hFFFFFFFF_C0000000, 64'hC000_0000_0000_0000, 5'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
